pipe_result_collector: RTL and testbench
========================================

Name: pipe_result_collector

Overview:
- Sink-side companion to the PIPE arithmetic block. Captures PIPE's free-running result stream (out_valid/out_value) into an 8-entry buffer.
- Re-presents the buffered results on a ready/valid interface so a slower downstream consumer can drain them.
- PIPE has no backpressure, so the block also reports overflow and keeps an accepted-result count for the verification harness.

Parameters:
- DATA_W, 27: width of one PIPE result word.
- DEPTH, 8: buffer entries; must be a power of 2, at least 2.
- CNT_W, 16: width of the accepted-result counter.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- pipe_valid  input  1  connects to PIPE out_valid; high = pipe_value holds a result this cycle.
- pipe_value  input  DATA_W  connects to PIPE out_value.
- res_valid  output  1  buffered result available.
- res_data  output  DATA_W  oldest buffered result.
- res_ready  input  1  downstream accepts res_data this cycle.
- clear  input  1  synchronous flush of buffer, overflow and counter.
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  output  1  level == DEPTH.
- overflow  output  1  sticky: at least one result was dropped.
- total_cnt  output  CNT_W  number of accepted results, saturating.

Behaviour:
- Reset (rst_n low, asynchronous): read and write pointers = 0, level = 0, res_valid = 0, full = 0, overflow = 0, total_cnt = 0. res_data is don't-care while res_valid = 0. Memory contents are not reset.
- Reset mid-operation discards all buffered data immediately. The first pipe_valid after rst_n deasserts is accepted normally.
- push = pipe_valid and (not full, or pop in the same cycle).
- pop = res_valid and res_ready. A pop while empty is impossible because res_valid = 0 when empty.
- Buffer is first-word-fall-through:
  - res_valid = (level != 0).
  - res_data = mem[rd_ptr], combinational from registered state.
  - Latency: a result pushed at edge N is visible on res_valid/res_data immediately after edge N.
- Full buffer:
  - pipe_valid with no pop: word is dropped, overflow set to 1 (sticky until clear or reset), total_cnt unchanged.
  - pipe_valid with a pop: push accepted, level stays DEPTH, no overflow.
- Empty buffer, pipe_valid and res_ready both high: the word is pushed and is not popped in that cycle, since res_valid was 0. Level goes 0 -> 1.
- Simultaneous push and pop (non-empty, non-full): level unchanged, both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Level is tracked separately, so full and empty are unambiguous.
- res_data must be stable while res_valid = 1 and res_ready = 0.
- total_cnt increments by 1 per accepted push and saturates at 2^CNT_W-1 with no wrap.
- clear (synchronous):
  - Sets pointers, level, overflow and total_cnt to 0 at the next edge.
  - Has priority over a push or pop in the same cycle; that cycle's pipe_valid word is discarded and overflow is not set.
  - res_valid = 0 from the cycle after clear.
- No arithmetic is performed on data. Words pass bit-exact, in order.

Test Plan:
1. Reset then 3 back-to-back pipe_valid words 27'h0000001, 27'h7FFFFFF, 27'h1234567 with res_ready = 0 -> level 3, res_data = 27'h0000001, total_cnt = 3. Then res_ready = 1 for 3 cycles -> outputs in order, level 0, res_valid = 0.
2. Push 8 words with res_ready = 0 -> full = 1. A 9th word with res_ready = 0 -> dropped, overflow = 1, total_cnt = 8. A 10th word with res_ready = 1 -> accepted, level stays 8, total_cnt = 9. Drained order is words 1-8 then word 10.
3. Continuous pipe_valid and res_ready for 20 cycles starting empty -> level toggles 0 -> 1 and then holds 1. Output sequence equals input sequence delayed one cycle, with pointer wrap across the 8-entry boundary. overflow stays 0.
4. Buffer holds 5 words, assert clear together with pipe_valid = 1 and res_ready = 1 -> next cycle level 0, res_valid = 0, overflow = 0, total_cnt = 0. The concurrent word is not stored.
5. Assert rst_n low mid-stream with level 4 and overflow = 1 -> all outputs read zero during reset. After release, a single push of 27'h0ABCDEF yields res_data = 27'h0ABCDEF and level = 1.
6. Force total_cnt to 16'hFFFE by pushing and popping continuously, then push 3 more -> total_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/pipe_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : pipe_result_collector
// Description : Captures the free-running PIPE result stream into a small
//               first-word-fall-through buffer and re-presents it on a
//               ready/valid interface. Reports sticky overflow (dropped
//               words) and a saturating count of accepted results.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_result_collector #(
    parameter int DATA_W = 27,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pipe_valid,
    input  logic [DATA_W-1:0]        pipe_value,
    output logic                     res_valid,
    output logic [DATA_W-1:0]        res_data,
    input  logic                     res_ready,
    input  logic                     clear,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     overflow,
    output logic [CNT_W-1:0]         total_cnt
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_lvl_w = c_ptr_w + 1;

    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_lvl_w-1:0] c_lvl_one  = c_lvl_w'(1);
    localparam logic [c_lvl_w-1:0] c_lvl_full = c_lvl_w'(DEPTH);
    localparam logic [CNT_W-1:0]   c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0]   c_cnt_max  = {CNT_W{1'b1}};

    // Storage is intentionally not reset; occupancy alone defines validity.
    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_lvl_w-1:0] r_level;
    logic               r_overflow;
    logic [CNT_W-1:0]   r_total_cnt;

    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;

    // Handshake decode: clear suppresses any push so the concurrent word is lost.
    always_comb begin
        w_full  = (r_level == c_lvl_full);
        w_empty = (r_level == '0);
        w_pop   = !w_empty && res_ready;
        w_push  = pipe_valid && (!w_full || w_pop) && !clear;
        w_drop  = pipe_valid && w_full && !w_pop && !clear;
    end

    // Word storage; written only on an accepted push.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= pipe_value;
        end
    end

    // Pointers and occupancy; level is kept separately so full/empty never alias.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + c_lvl_one;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - c_lvl_one;
            end
        end
    end

    // Sticky overflow flag, set when a word arrives with no room.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    // Saturating count of accepted words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_total_cnt <= '0;
        end else if (clear) begin
            r_total_cnt <= '0;
        end else if (w_push && (r_total_cnt != c_cnt_max)) begin
            r_total_cnt <= r_total_cnt + c_cnt_one;
        end
    end

    // Output mapping; head word falls through combinationally.
    always_comb begin
        res_valid = !w_empty;
        res_data  = r_mem[r_rd_ptr];
        level     = r_level;
        full      = w_full;
        overflow  = r_overflow;
        total_cnt = r_total_cnt;
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_result_collector
// Description : Directed testbench with scoreboard queue for
//               pipe_result_collector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_result_collector;

    localparam int DATA_W = 27;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              rst_n;
    logic              pipe_valid;
    logic [DATA_W-1:0] pipe_value;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              res_ready;
    logic              clear;
    logic [3:0]        level;
    logic              full;
    logic              overflow;
    logic [CNT_W-1:0]  total_cnt;

    logic [DATA_W-1:0] exp_q[$];
    int                checks;
    int                errors;

    pipe_result_collector #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pipe_valid (pipe_valid),
        .pipe_value (pipe_value),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_ready  (res_ready),
        .clear      (clear),
        .level      (level),
        .full       (full),
        .overflow   (overflow),
        .total_cnt  (total_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: every handshake seen mid-cycle must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got %h expected none", res_data);
            end else begin
                check("res_data", 32'(res_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // One clock of stimulus; acc says whether the word must be stored.
    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic rdy,
                        input logic clr, input logic acc);
        pipe_valid = v;
        pipe_value = d;
        res_ready  = rdy;
        clear      = clr;
        if (acc) exp_q.push_back(d);
        @(posedge clk);
        #1;
        if (clr) exp_q.delete();
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        pipe_valid = 1'b0;
        pipe_value = '0;
        res_ready  = 1'b0;
        clear      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_level",     32'(level),     32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_full",      32'(full),      32'd0);
        check("rst_overflow",  32'(overflow),  32'd0);
        check("rst_total_cnt", 32'(total_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: three words, then drain
        step(1'b1, 27'h0000001, 1'b0, 1'b0, 1'b1);
        check("t1_latency_valid", 32'(res_valid), 32'd1);
        check("t1_latency_data",  32'(res_data),  32'h0000001);
        step(1'b1, 27'h7FFFFFF, 1'b0, 1'b0, 1'b1);
        step(1'b1, 27'h1234567, 1'b0, 1'b0, 1'b1);
        idle();
        check("t1_level",     32'(level),     32'd3);
        check("t1_head",      32'(res_data),  32'h0000001);
        check("t1_total_cnt", 32'(total_cnt), 32'd3);
        check("t1_stable",    32'(res_data),  32'h0000001);
        repeat (3) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("t1_drain_level", 32'(level),       32'd0);
        check("t1_drain_valid", 32'(res_valid),   32'd0);
        check("t1_q_empty",     32'(exp_q.size()), 32'd0);

        // Test 2: fill, drop, accept-on-pop when full
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 8; i++) step(1'b1, DATA_W'(32'h100 + i), 1'b0, 1'b0, 1'b1);
        check("t2_full",  32'(full),  32'd1);
        check("t2_level", 32'(level), 32'd8);
        check("t2_ovf_before", 32'(overflow), 32'd0);
        step(1'b1, 27'h0000900, 1'b0, 1'b0, 1'b0);
        check("t2_overflow", 32'(overflow),  32'd1);
        check("t2_cnt_drop", 32'(total_cnt), 32'd8);
        step(1'b1, 27'h0000A00, 1'b1, 1'b0, 1'b1);
        check("t2_level_keep", 32'(level),     32'd8);
        check("t2_cnt_accept", 32'(total_cnt), 32'd9);
        check("t2_ovf_sticky", 32'(overflow),  32'd1);
        repeat (8) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("t2_drain_level", 32'(level),        32'd0);
        check("t2_q_empty",     32'(exp_q.size()), 32'd0);

        // Test 3: streaming with pointer wrap
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, DATA_W'(32'h3000 + i), 1'b1, 1'b0, 1'b1);
            check("t3_level", 32'(level), 32'd1);
        end
        check("t3_overflow", 32'(overflow),  32'd0);
        check("t3_cnt",      32'(total_cnt), 32'd20);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("t3_q_empty", 32'(exp_q.size()), 32'd0);
        check("t3_level_end", 32'(level), 32'd0);

        // Test 4: clear beats concurrent push and pop
        for (int i = 0; i < 5; i++) step(1'b1, DATA_W'(32'h4000 + i), 1'b0, 1'b0, 1'b1);
        check("t4_level_pre", 32'(level), 32'd5);
        step(1'b1, 27'h5555555, 1'b1, 1'b1, 1'b0);
        check("t4_level",     32'(level),     32'd0);
        check("t4_res_valid", 32'(res_valid), 32'd0);
        check("t4_overflow",  32'(overflow),  32'd0);
        check("t4_total_cnt", 32'(total_cnt), 32'd0);
        repeat (2) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Test 5: asynchronous reset mid-stream
        for (int i = 0; i < 8; i++) step(1'b1, DATA_W'(32'h5000 + i), 1'b0, 1'b0, 1'b1);
        step(1'b1, 27'h5FFFFFF, 1'b0, 1'b0, 1'b0);
        repeat (4) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("t5_level_pre", 32'(level),    32'd4);
        check("t5_ovf_pre",   32'(overflow), 32'd1);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("t5_rst_level",  32'(level),     32'd0);
        check("t5_rst_valid",  32'(res_valid), 32'd0);
        check("t5_rst_full",   32'(full),      32'd0);
        check("t5_rst_ovf",    32'(overflow),  32'd0);
        check("t5_rst_cnt",    32'(total_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 27'h0ABCDEF, 1'b0, 1'b0, 1'b1);
        check("t5_data",  32'(res_data),  32'h0ABCDEF);
        check("t5_level", 32'(level),     32'd1);
        check("t5_cnt",   32'(total_cnt), 32'd1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Test 6: counter saturation
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 65534; i++) step(1'b1, DATA_W'(i), 1'b1, 1'b0, 1'b1);
        check("t6_cnt_fffe", 32'(total_cnt), 32'h0000FFFE);
        step(1'b1, 27'h6000001, 1'b1, 1'b0, 1'b1);
        check("t6_cnt_ffff", 32'(total_cnt), 32'h0000FFFF);
        step(1'b1, 27'h6000002, 1'b1, 1'b0, 1'b1);
        step(1'b1, 27'h6000003, 1'b1, 1'b0, 1'b1);
        check("t6_cnt_sat",  32'(total_cnt), 32'h0000FFFF);
        check("t6_overflow", 32'(overflow),  32'd0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("t6_q_empty", 32'(exp_q.size()), 32'd0);
        check("t6_level",   32'(level),        32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
